// File: rtl/fetch_align.sv
// Fetch sequencer and halfword aligner: word fetches in, one 16/32-bit
// instruction per handshake out, with redirect flush and stale-response drop.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH_HW = 4
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  output logic        O_mem_req,
  output logic [31:0] O_mem_addr,
  input  logic        I_mem_valid,
  input  logic [31:0] I_mem_data,
  output logic        O_valid,
  output logic [31:0] O_instr,
  output logic        O_len,
  output logic [31:0] O_pc,
  input  logic        I_ready
);

  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [15:0]     buf_q [DEPTH_HW];
  logic [15:0]     buf_d [DEPTH_HW];
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     faddr_q, faddr_d;
  logic            skip_q, skip_d;

  logic [15:0]     h0, h1;
  logic            is32, avail, pop, push;
  logic [PW-1:0]   tail, tail1;
  logic [CW-1:0]   npush, npop;

  assign h0    = buf_q[head_q];
  assign h1    = buf_q[head_q + PW'(1)];
  assign is32  = (h0[1:0] == 2'b11);
  assign avail = (count_q != '0 && !is32)
              || (is32 && count_q >= CW'(2));
  assign pop   = avail && I_ready && !I_redirect;
  assign push  = (state_q == WAIT) && I_mem_valid && !I_redirect;
  assign tail  = head_q + count_q[PW-1:0];
  assign tail1 = tail + PW'(1);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (O_mem_req) state_d = WAIT;
      WAIT: begin
        if (I_mem_valid)     state_d = IDLE;
        else if (I_redirect) state_d = DROP;
      end
      DROP: if (I_mem_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    O_mem_req  = (state_q == IDLE) && !I_redirect && !I_rst
              && (count_q <= CW'(DEPTH_HW - 2));
    O_mem_addr = faddr_q;
    O_valid    = avail;
    O_len      = avail && is32;
    O_pc       = pc_q;
    O_instr    = '0;
    if (avail) O_instr = is32 ? {h1, h0} : {16'h0000, h0};
  end

  always_comb begin
    buf_d   = buf_q;
    head_d  = head_q;
    count_d = count_q;
    pc_d    = pc_q;
    faddr_d = faddr_q;
    skip_d  = skip_q;
    npush   = '0;
    npop    = '0;
    if (I_redirect) begin
      count_d = '0;
      pc_d    = I_redirect_pc & ~32'h1;
      faddr_d = I_redirect_pc & ~32'h3;
      skip_d  = I_redirect_pc[1];
    end else begin
      if (push) begin
        // after a mid-word redirect the low halfword precedes the target
        if (skip_q) begin
          buf_d[tail] = I_mem_data[31:16];
          npush       = CW'(1);
          skip_d      = 1'b0;
        end else begin
          buf_d[tail]  = I_mem_data[15:0];
          buf_d[tail1] = I_mem_data[31:16];
          npush        = CW'(2);
        end
        faddr_d = faddr_q + 32'd4;
      end
      if (pop) begin
        npop   = is32 ? CW'(2) : CW'(1);
        head_d = head_q + npop[PW-1:0];
        pc_d   = pc_q + (is32 ? 32'd4 : 32'd2);
      end
      count_d = count_q + npush - npop;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      count_q <= '0;
      head_q  <= '0;
      pc_q    <= RESET_PC & ~32'h1;
      faddr_q <= RESET_PC & ~32'h3;
      skip_q  <= RESET_PC[1];
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      pc_q    <= pc_d;
      faddr_q <= faddr_d;
      skip_q  <= skip_d;
    end
  end

  always_ff @(posedge I_clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: directed scenarios then random traffic, checked
// against an ideal instruction-stream model read straight from a memory image.
module tb_fetch_align;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        I_clk, I_rst, I_redirect, I_mem_valid, I_ready;
  logic [31:0] I_redirect_pc, I_mem_data;
  logic        O_mem_req, O_valid, O_len;
  logic [31:0] O_mem_addr, O_instr, O_pc;

  fetch_align #(.RESET_PC(RPC), .DEPTH_HW(4)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_redirect(I_redirect), .I_redirect_pc(I_redirect_pc),
    .O_mem_req(O_mem_req), .O_mem_addr(O_mem_addr),
    .I_mem_valid(I_mem_valid), .I_mem_data(I_mem_data),
    .O_valid(O_valid), .O_instr(O_instr), .O_len(O_len),
    .O_pc(O_pc), .I_ready(I_ready)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];
  logic        rst_v;
  logic        pend;
  logic [31:0] paddr;
  int          wcnt, lat_lo, lat_hi, nreq, gap;
  logic [31:0] mpc;
  logic        obs_valid, obs_req, req_seen;
  logic [31:0] obs_instr, obs_pc, req_addr;
  logic        obs_len;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    return h;
  endfunction

  function automatic logic [15:0] memhw(input logic [31:0] a);
    logic [31:0] w;
    w = memword({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic redir, input logic [31:0] rpc,
                       input logic rdy);
    logic [15:0] h0;
    logic        e32;
    logic [31:0] ei;
    @(negedge I_clk);
    I_rst         = rst_v;
    I_redirect    = redir;
    I_redirect_pc = rpc;
    I_ready       = rdy;
    I_mem_valid   = 1'b0;
    I_mem_data    = $urandom;
    if (rst_v) pend = 1'b0;
    else if (pend) begin
      if (wcnt == 0) begin
        I_mem_valid = 1'b1;
        I_mem_data  = memword(paddr);
        pend        = 1'b0;
      end else wcnt--;
    end
    #1;
    obs_valid = O_valid;
    obs_instr = O_instr;
    obs_len   = O_len;
    obs_pc    = O_pc;
    obs_req   = O_mem_req;
    req_seen  = O_mem_req;
    if (rst_v) mpc = RPC & ~32'h1;
    h0  = memhw(mpc);
    e32 = (h0[1:0] == 2'b11);
    ei  = e32 ? {memhw(mpc + 32'd2), h0} : {16'h0000, h0};
    if (O_valid) begin
      chk("pc", O_pc, mpc);
      chk("instr", O_instr, ei);
      chk("len", {31'b0, O_len}, {31'b0, e32});
      gap = 0;
    end else begin
      chk("instr_idle", O_instr, 32'h0);
      gap++;
      chk("liveness", {31'b0, gap > 40}, 32'h0);
      if (gap > 40) gap = 0;
    end
    if (O_mem_req) begin
      chk("one_outstanding", {31'b0, pend}, 32'h0);
      chk("addr_align", {30'b0, O_mem_addr[1:0]}, 32'h0);
      pend     = 1'b1;
      paddr    = O_mem_addr;
      req_addr = O_mem_addr;
      wcnt     = $urandom_range(lat_hi, lat_lo);
      nreq++;
    end
    if (!rst_v) begin
      if (redir) mpc = rpc & ~32'h1;
      else if (O_valid && rdy) mpc = mpc + (e32 ? 32'd4 : 32'd2);
    end
  endtask

  task automatic wait_valid(input logic rdy);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 32'h0, rdy);
      if (obs_valid) break;
    end
  endtask

  task automatic wait_req(input logic rdy);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 32'h0, rdy);
      if (req_seen) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    I_rst = 1'b1; I_redirect = 1'b0; I_redirect_pc = '0;
    I_mem_valid = 1'b0; I_mem_data = '0; I_ready = 1'b0;
    rst_v = 1'b1; pend = 1'b0; paddr = '0; wcnt = 0; nreq = 0;
    lat_lo = 0; lat_hi = 0; gap = 0; mpc = RPC;
    req_addr = '0;
    mem[32'h100] = 32'h00B5_0513;

    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    chk("rst_valid", {31'b0, obs_valid}, 32'h0);
    chk("rst_pc", obs_pc, RPC);
    chk("rst_req", {31'b0, obs_req}, 32'h0);
    chk("rst_len", {31'b0, obs_len}, 32'h0);

    // reset release: first request to RESET_PC word
    rst_v = 1'b0;
    cycle(1'b0, 32'h0, 1'b0);
    chk("t1_req", {31'b0, req_seen}, 32'h1);
    chk("t1_addr", req_addr, 32'h100);
    wait_valid(1'b0);
    chk("t1_valid", {31'b0, obs_valid}, 32'h1);
    chk("t1_instr", obs_instr, 32'h00B5_0513);
    chk("t1_len", {31'b0, obs_len}, 32'h1);
    chk("t1_pc", obs_pc, 32'h100);

    // two compressed halfwords in one word
    cycle(1'b1, 32'h0, 1'b0);
    mem[32'h0] = 32'h4501_4581;
    wait_valid(1'b1);
    chk("t2_instr0", obs_instr, 32'h0000_4581);
    chk("t2_pc0", obs_pc, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t2_valid1", {31'b0, obs_valid}, 32'h1);
    chk("t2_instr1", obs_instr, 32'h0000_4501);
    chk("t2_pc1", obs_pc, 32'h2);
    chk("t2_len1", {31'b0, obs_len}, 32'h0);

    // 32-bit instruction straddling two words
    lat_lo = 3; lat_hi = 3;
    cycle(1'b1, 32'h0, 1'b0);
    mem[32'h0] = 32'h0513_4501;
    mem[32'h4] = 32'h0000_00B5;
    wait_valid(1'b1);
    chk("t3_instr0", obs_instr, 32'h0000_4501);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t3_gap", {31'b0, obs_valid}, 32'h0);
    wait_valid(1'b1);
    chk("t3_instr1", obs_instr, 32'h00B5_0513);
    chk("t3_pc1", obs_pc, 32'h2);
    chk("t3_len1", {31'b0, obs_len}, 32'h1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t3_pc2", obs_pc, 32'h6);

    // redirect to a mid-word target while a fetch is outstanding
    cycle(1'b1, 32'h200, 1'b0);
    wait_req(1'b0);
    chk("t4_addr200", req_addr, 32'h200);
    cycle(1'b1, 32'h206, 1'b0);
    chk("t4_noreq", {31'b0, obs_req}, 32'h0);
    mem[32'h204] = 32'h4581_FFFF;
    mem[32'h208] = 32'h0000_4501;
    wait_req(1'b0);
    chk("t4_addr204", req_addr, 32'h204);
    wait_valid(1'b0);
    chk("t4_pc", obs_pc, 32'h206);
    chk("t4_instr", obs_instr, 32'h0000_4581);
    cycle(1'b0, 32'h0, 1'b1);
    wait_valid(1'b1);
    chk("t4_pc2", obs_pc, 32'h208);
    chk("t4_instr2", obs_instr, 32'h0000_4501);

    // buffer fills with compressed stream while the decoder stalls
    lat_lo = 0; lat_hi = 0;
    cycle(1'b1, 32'h300, 1'b0);
    mem[32'h300] = 32'h4501_4581;
    mem[32'h304] = 32'h4521_4511;
    mem[32'h308] = 32'h4541_4531;
    mem[32'h30C] = 32'h4561_4551;
    nreq = 0;
    repeat (12) cycle(1'b0, 32'h0, 1'b0);
    chk("t5_nreq", nreq, 32'd2);
    chk("t5_noreq", {31'b0, obs_req}, 32'h0);
    chk("t5_pc", obs_pc, 32'h300);
    chk("t5_instr", obs_instr, 32'h0000_4581);
    wait_req(1'b1);
    chk("t5_resume", req_addr, 32'h308);

    // asynchronous reset while a fetch is outstanding
    lat_lo = 5; lat_hi = 5;
    cycle(1'b1, 32'h400, 1'b0);
    wait_req(1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    #2;
    I_rst = 1'b1;
    rst_v = 1'b1;
    #1;
    chk("t6_valid", {31'b0, O_valid}, 32'h0);
    chk("t6_pc", O_pc, RPC);
    chk("t6_req", {31'b0, O_mem_req}, 32'h0);
    pend = 1'b0;
    mpc  = RPC;
    gap  = 0;
    repeat (2) cycle(1'b0, 32'h0, 1'b0);
    lat_lo = 0; lat_hi = 3;
    rst_v = 1'b0;
    cycle(1'b0, 32'h0, 1'b0);
    chk("t6_req_after", {31'b0, req_seen}, 32'h1);
    chk("t6_addr", req_addr, 32'h100);

    // random traffic, including redirects near the top of the address space
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] tgt;
      rd  = ($urandom_range(99, 0) < 3);
      tgt = ($urandom_range(9, 0) == 0)
          ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
          : ($urandom & 32'h0000_0FFF);
      cycle(rd, tgt, $urandom_range(9, 0) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- Instruction fetch sequencer and halfword aligner in front of the decoder.
- Issues word-aligned fetches to instruction memory and buffers the returned halfwords.
- Presents one instruction per handshake: a 32-bit instruction, or a 16-bit compressed one zero-extended in the upper half.
- Tracks the instruction PC, and handles redirects (branches/jumps) by flushing the buffer and discarding stale responses.

Parameters:
- RESET_PC, 32'h00000000, PC after reset; bit 0 ignored.
- DEPTH_HW, 4, halfword buffer entries; power of 2, minimum 4.

Ports:
- I_clk  in  1  clock, rising edge.
- I_rst  in  1  reset, asynchronous, active-high.
- I_redirect  in  1  load new PC, flush the buffer.
- I_redirect_pc  in  32  redirect target; bit 0 ignored.
- O_mem_req  out  1  fetch request, valid for one cycle.
- O_mem_addr  out  32  fetch word address; bits [1:0] are always 00.
- I_mem_valid  in  1  fetch response valid.
- I_mem_data  in  32  fetch response word, little-endian halfwords.
- O_valid  out  1  instruction available.
- O_instr  out  32  instruction: {h1,h0} for 32-bit, {16'h0000,h0} for 16-bit.
- O_len  out  1  1 = 32-bit instruction, 0 = 16-bit.
- O_pc  out  32  address of O_instr.
- I_ready  in  1  decoder accepts the instruction.

Behaviour:
- Reset: buffer count 0, state IDLE, O_pc = RESET_PC with bit 0 cleared, fetch_addr = {RESET_PC[31:2],2'b00}, skip = RESET_PC[1]. O_valid 0, O_instr 0, O_len 0, O_mem_req 0.
- Reset asserted mid-operation: outstanding request is forgotten. Memory must not deliver I_mem_valid after a reset for a pre-reset request.
- State machine:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; data is kept.
  - DROP: one request outstanding; data is discarded.
- Request issue: O_mem_req = (state==IDLE) && !I_redirect && (count <= DEPTH_HW-2). O_mem_addr = fetch_addr (combinational). Same cycle, IDLE -> WAIT.
- Memory rules: request is sampled at the clock edge. Response arrives no earlier than the next cycle. At most one request is outstanding.
- WAIT with I_mem_valid and no redirect:
  - If skip=0, push low then high halfword (+2).
  - If skip=1, push high halfword only (+1), then clear skip.
  - fetch_addr += 4; state -> IDLE.
- DROP with I_mem_valid: data discarded, state -> IDLE.
- Output is combinational from registered state, with h0 = head and h1 = next entry:
  - count>=1 and h0[1:0]!=2'b11: O_valid=1, O_len=0.
  - h0[1:0]==2'b11 and count>=2: O_valid=1, O_len=1.
  - Otherwise: O_valid=0, O_instr=0.
- Pop: on O_valid && I_ready, remove 1 or 2 halfwords and add 2 or 4 to O_pc. 32-bit arithmetic, wraps at 2^32.
- Push and pop in the same cycle are both allowed: count += pushed - popped. Count never exceeds DEPTH_HW (guaranteed by the issue condition).
- Redirect takes priority over everything else in that cycle:
  - count = 0 and any pop is ignored.
  - O_pc = {I_redirect_pc[31:1],1'b0}; fetch_addr = {I_redirect_pc[31:2],2'b00}; skip = I_redirect_pc[1].
  - State: WAIT -> DROP, and DROP stays DROP. IDLE stays IDLE, with no request issued this cycle.
  - Coincident I_mem_valid is discarded and state -> IDLE, from both WAIT and DROP.
- O_instr/O_len/O_pc stay stable while O_valid && !I_ready, absent a redirect.
- Halfword 16'h0000 is passed as a normal 16-bit instruction; legality checking belongs to the decoder.

Test Plan:
- Reset release, RESET_PC=0x100, memory returns 0x00B50513 one cycle after the request -> O_mem_req with addr 0x100 on the first cycle; then O_valid=1, O_instr=0x00B50513, O_len=1, O_pc=0x100.
- Word 0x45014581 at 0x0, I_ready=1 -> O_instr 0x00004581 at pc 0x0, then 0x00004501 at pc 0x2, both with O_len=0.
- Word 0x05134501 at 0x0, then 0x000000B5 at 0x4 -> 0x00004501 at pc 0x0; O_valid=0 until the second word arrives; then 0x00B50513 at pc 0x2, O_len=1, next pc 0x6.
- Redirect to 0x206 while in WAIT -> stale response ignored (DROP); next request addr 0x204; only the high halfword is buffered; O_pc=0x206.
- I_ready=0 with compressed-only stream, DEPTH_HW=4 -> count reaches 4, O_mem_req stays 0, outputs stable; I_ready=1 resumes fetching at the correct address.
- I_rst asserted during WAIT -> O_valid=0 and O_pc=RESET_PC immediately (asynchronous); after release, a new request is issued at the RESET_PC word.
